cvxif_pau_arbiter: RTL
======================

Name: cvxif_pau_arbiter

Overview:
- Shares one cvxif_pau coprocessor between two CV-X-IF requesters (m0, m1), e.g. two cores or a core plus a DMA-driven test master.
- Arbitrates the issue channel round-robin and locks the register channel to the winner until its operands are delivered.
- Returns results in order by tracking, in an owner FIFO, which requester each writeback instruction belongs to.
- Sits between requester CV-X-IF ports and the pau's issue/register/result ports.

Parameters:
- OWN_DEPTH, 4, max in-flight writeback instructions (owner FIFO entries, power of two, ≥2).
- XLEN, 32, instruction/operand/result width.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- mN_issue_valid / mN_issue_ready  in/out  1/1  requester N issue handshake (N=0,1).
- mN_issue_req_instr  in  XLEN  requester N instruction.
- mN_issue_resp_accept / _writeback  out  1/1  response, valid with the issue handshake.
- mN_issue_resp_register_read  out  2  rs0/rs1 needed.
- mN_register_valid / mN_register_ready  in/out  1/1  requester N operand handshake.
- mN_register_rs0, mN_register_rs1  in  XLEN  operands.
- mN_register_rs_valid  in  2  operand valid bits.
- mN_result_valid / mN_result_ready  out/in  1/1  result handshake.
- mN_result_data  out  XLEN  result.
- p_issue_valid, p_issue_req_instr  out  1, XLEN  to pau.
- p_issue_ready, p_issue_resp_accept, p_issue_resp_writeback, p_issue_resp_register_read  in  1,1,1,2  from pau.
- p_register_valid, p_register_rs0, p_register_rs1, p_register_rs_valid  out  1, XLEN, XLEN, 2  to pau.
- p_register_ready  in  1  from pau.
- p_result_valid, p_result_data  in  1, XLEN  from pau.
- p_result_ready  out  1  to pau.

Behaviour:
- Reset (rst=0, async): state=ARB, rr_ptr=0 (m0 first), FIFO empty, all outputs 0. Mid-transaction reset drops all in-flight ownership; the pau must be reset together.
- States:
  - ARB: issue arbitration open.
  - ISSUE: winner held, instruction presented to pau.
  - REG: register channel locked to owner.
- ARB:
  - If FIFO full, grant nothing; both mN_issue_ready=0.
  - Otherwise pick a requester with issue_valid, priority from rr_ptr, and latch grant in one cycle (no combinational valid→ready path).
  - Go to ISSUE.
- ISSUE:
  - p_issue_valid=1 with the granted instr; mG_issue_ready=p_issue_ready; loser sees ready=0.
  - On handshake, resp_* forward to the winner in the same cycle (others 0), and rr_ptr toggles to the other requester.
  - If accept & writeback, push G into the FIFO.
  - If accept & register_read≠0, go to REG; else go to ARB.
  - An unaccepted instruction is still a completed handshake: nothing is pushed and there is no register phase.
- REG:
  - p_register_* come from mG; mG_register_ready=p_register_ready; the other requester's register_ready=0.
  - On handshake, go to ARB.
  - Issue arbitration is blocked while in REG.
- Result path, independent of the FSM:
  - Head owner H receives the result: mH_result_valid=p_result_valid, mH_result_data=p_result_data, p_result_ready=mH_result_ready.
  - If the FIFO is empty, p_result_ready=0 and all mN_result_valid=0.
  - Pop on result handshake.
- Simultaneous push and pop in one cycle is legal, including when full (count unchanged).
- FIFO pointers wrap modulo OWN_DEPTH; count is width clog2(OWN_DEPTH)+1.
- Issue-to-pau latency: 1 cycle after valid (ARB→ISSUE); 0 added latency on result.

Optional Feature:
- PAU_ARB_PERF_EN defined adds outputs:
  - perf_grant0, perf_grant1 (32b): accepted issues per requester.
  - perf_stall (32b): cycles with any mN_issue_valid=1 and FIFO full or state=REG.
- All three counters wrap, are cleared by reset, and are cleared synchronously by input perf_clr (1b).
- Undefined: these ports and counters do not exist; behaviour otherwise identical.

Test Plan:
- Both valid from reset, pau accepts all with writeback=1, register_read=0 → grants alternate m0,m1,m0,m1; results return to m0,m1,m0,m1 in order.
- m1 issues instr 0x0000_120B with register_read=2'b11; m0 is valid meanwhile → m1 rs0=0xA5A5_0001, rs1=0x5A5A_0002 reach pau; m0 gets no issue_ready until m1's register handshake completes.
- Four writeback issues with result_ready=0 → FIFO full; fifth issue_valid sees ready=0; one result pop in the same cycle as the next issue → the issue proceeds, count stays 4.
- pau responds accept=0 → requester sees accept=0 with the handshake; FIFO count unchanged; no register phase.
- Assert rst=0 while in REG with 2 entries queued → all outputs 0 immediately; after release state=ARB, FIFO empty, m0 has priority.
- With PAU_ARB_PERF_EN: 3 m0 grants, 2 m1 grants, 5 full-stall cycles → perf_grant0=3, perf_grant1=2, perf_stall=5; perf_clr=1 → all 0 next cycle.

Source files
------------

// File: rtl/cvxif_pau_arbiter.sv
// Two-requester CV-X-IF front end for a shared cvxif_pau: round-robin issue arbitration,
// register-channel lock to the issuing requester, and in-order result routing via an owner FIFO.
// Optional build macro PAU_ARB_PERF_EN adds grant/stall performance counters and a perf_clr input.
module cvxif_pau_arbiter #(
    parameter int OWN_DEPTH = 4,
    parameter int XLEN      = 32
) (
    input  logic            clk,
    input  logic            rst,

    input  logic            m0_issue_valid,
    output logic            m0_issue_ready,
    input  logic [XLEN-1:0] m0_issue_req_instr,
    output logic            m0_issue_resp_accept,
    output logic            m0_issue_resp_writeback,
    output logic [1:0]      m0_issue_resp_register_read,
    input  logic            m0_register_valid,
    output logic            m0_register_ready,
    input  logic [XLEN-1:0] m0_register_rs0,
    input  logic [XLEN-1:0] m0_register_rs1,
    input  logic [1:0]      m0_register_rs_valid,
    output logic            m0_result_valid,
    input  logic            m0_result_ready,
    output logic [XLEN-1:0] m0_result_data,

    input  logic            m1_issue_valid,
    output logic            m1_issue_ready,
    input  logic [XLEN-1:0] m1_issue_req_instr,
    output logic            m1_issue_resp_accept,
    output logic            m1_issue_resp_writeback,
    output logic [1:0]      m1_issue_resp_register_read,
    input  logic            m1_register_valid,
    output logic            m1_register_ready,
    input  logic [XLEN-1:0] m1_register_rs0,
    input  logic [XLEN-1:0] m1_register_rs1,
    input  logic [1:0]      m1_register_rs_valid,
    output logic            m1_result_valid,
    input  logic            m1_result_ready,
    output logic [XLEN-1:0] m1_result_data,

    output logic            p_issue_valid,
    output logic [XLEN-1:0] p_issue_req_instr,
    input  logic            p_issue_ready,
    input  logic            p_issue_resp_accept,
    input  logic            p_issue_resp_writeback,
    input  logic [1:0]      p_issue_resp_register_read,
    output logic            p_register_valid,
    output logic [XLEN-1:0] p_register_rs0,
    output logic [XLEN-1:0] p_register_rs1,
    output logic [1:0]      p_register_rs_valid,
    input  logic            p_register_ready,
    input  logic            p_result_valid,
    input  logic [XLEN-1:0] p_result_data,
    output logic            p_result_ready
`ifdef PAU_ARB_PERF_EN
    ,
    input  logic            perf_clr,
    output logic [31:0]     perf_grant0,
    output logic [31:0]     perf_grant1,
    output logic [31:0]     perf_stall
`endif
);

    localparam int            PW         = $clog2(OWN_DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(OWN_DEPTH);

    localparam logic [1:0] ST_ARB   = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_REG   = 2'd2;

    logic [1:0]           r_state;
    logic                 r_rr_ptr;
    logic                 r_gnt;
    logic [OWN_DEPTH-1:0] r_own;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic w_in_issue;
    logic w_in_reg;
    logic w_full;
    logic w_empty;
    logic w_any_valid;
    logic w_pick;
    logic w_issue_hs;
    logic w_push;
    logic w_reg_valid;
    logic w_head;
    logic w_head_ready;
    logic w_pop;
    logic w_res_to0;
    logic w_res_to1;

    assign w_in_issue  = (r_state == ST_ISSUE);
    assign w_in_reg    = (r_state == ST_REG);
    assign w_full      = (r_count == FULL_COUNT);
    assign w_empty     = (r_count == '0);
    assign w_any_valid = m0_issue_valid | m1_issue_valid;
    // Preferred requester wins if valid, otherwise the other one (only used when w_any_valid).
    assign w_pick      = r_rr_ptr ? m1_issue_valid : ~m0_issue_valid;
    assign w_issue_hs  = w_in_issue & p_issue_ready;
    assign w_push      = w_issue_hs & p_issue_resp_accept & p_issue_resp_writeback;
    assign w_reg_valid = r_gnt ? m1_register_valid : m0_register_valid;

    assign w_head       = r_own[r_rd_ptr];
    assign w_head_ready = w_head ? m1_result_ready : m0_result_ready;
    assign w_pop        = ~w_empty & p_result_valid & w_head_ready;
    assign w_res_to0    = ~w_empty & ~w_head;
    assign w_res_to1    = ~w_empty &  w_head;

    // Issue ready is driven only from the registered grant, never from the requester's valid.
    assign p_issue_valid     = w_in_issue;
    assign p_issue_req_instr = {XLEN{w_in_issue}} & (r_gnt ? m1_issue_req_instr : m0_issue_req_instr);
    assign m0_issue_ready    = w_in_issue & ~r_gnt & p_issue_ready;
    assign m1_issue_ready    = w_in_issue &  r_gnt & p_issue_ready;

    assign m0_issue_resp_accept        = w_issue_hs & ~r_gnt & p_issue_resp_accept;
    assign m0_issue_resp_writeback     = w_issue_hs & ~r_gnt & p_issue_resp_writeback;
    assign m0_issue_resp_register_read = {2{w_issue_hs & ~r_gnt}} & p_issue_resp_register_read;
    assign m1_issue_resp_accept        = w_issue_hs &  r_gnt & p_issue_resp_accept;
    assign m1_issue_resp_writeback     = w_issue_hs &  r_gnt & p_issue_resp_writeback;
    assign m1_issue_resp_register_read = {2{w_issue_hs & r_gnt}} & p_issue_resp_register_read;

    assign p_register_valid    = w_in_reg & w_reg_valid;
    assign p_register_rs0      = {XLEN{w_in_reg}} & (r_gnt ? m1_register_rs0 : m0_register_rs0);
    assign p_register_rs1      = {XLEN{w_in_reg}} & (r_gnt ? m1_register_rs1 : m0_register_rs1);
    assign p_register_rs_valid = {2{w_in_reg}} & (r_gnt ? m1_register_rs_valid : m0_register_rs_valid);
    assign m0_register_ready   = w_in_reg & ~r_gnt & p_register_ready;
    assign m1_register_ready   = w_in_reg &  r_gnt & p_register_ready;

    assign m0_result_valid = w_res_to0 & p_result_valid;
    assign m1_result_valid = w_res_to1 & p_result_valid;
    assign m0_result_data  = {XLEN{w_res_to0}} & p_result_data;
    assign m1_result_data  = {XLEN{w_res_to1}} & p_result_data;
    assign p_result_ready  = ~w_empty & w_head_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= ST_ARB;
            r_rr_ptr <= 1'b0;
            r_gnt    <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (!w_full && w_any_valid) begin
                        r_gnt   <= w_pick;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (p_issue_ready) begin
                        r_rr_ptr <= ~r_gnt;
                        if (p_issue_resp_accept && (p_issue_resp_register_read != 2'b00))
                            r_state <= ST_REG;
                        else
                            r_state <= ST_ARB;
                    end
                end
                ST_REG: begin
                    if (w_reg_valid && p_register_ready)
                        r_state <= ST_ARB;
                end
                default: r_state <= ST_ARB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // NOTE: owner storage has no reset; r_count alone decides which entries are live.
    always_ff @(posedge clk) begin
        if (w_push)
            r_own[r_wr_ptr] <= r_gnt;
    end

`ifdef PAU_ARB_PERF_EN
    logic [31:0] r_perf_grant0;
    logic [31:0] r_perf_grant1;
    logic [31:0] r_perf_stall;
    logic        w_stall_cycle;

    assign w_stall_cycle = w_any_valid & (w_full | w_in_reg);
    assign perf_grant0   = r_perf_grant0;
    assign perf_grant1   = r_perf_grant1;
    assign perf_stall    = r_perf_stall;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_grant0 <= '0;
            r_perf_grant1 <= '0;
            r_perf_stall  <= '0;
        end else if (perf_clr) begin
            r_perf_grant0 <= '0;
            r_perf_grant1 <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (w_issue_hs && p_issue_resp_accept && !r_gnt)
                r_perf_grant0 <= r_perf_grant0 + 32'd1;
            if (w_issue_hs && p_issue_resp_accept && r_gnt)
                r_perf_grant1 <= r_perf_grant1 + 32'd1;
            if (w_stall_cycle)
                r_perf_stall <= r_perf_stall + 32'd1;
        end
    end
`endif

endmodule
